// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions used by the fetch sequencer: FSM states, instruction
// size, the NOP encoding and a word-alignment helper.
package fetch_ctrl_pkg;

    typedef enum logic [0:0] {
        FC_REQ   = 1'b0,
        FC_VALID = 1'b1
    } fc_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC write port, the imem handshake and a
// one-entry IF/ID buffer. Optional counters are enabled with FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_out,
    output logic [31:0] PC_next,
    output logic        PCWrite,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [31:0] if_pc
);

    fc_state_e   state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        buf_load;
    logic        stall_hit;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        PC_next      = PC_out;
        PCWrite      = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = PC_out;
        buf_load     = 1'b0;
        stall_hit    = 1'b0;

        unique case (state_q)
            FC_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    PCWrite = 1'b1;
                    if (redirect_valid || pend_valid_q) begin
                        // Data belongs to the wrong path; refetch at the target.
                        PC_next      = redirect_valid ? word_align(redirect_pc) : pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        PC_next    = PC_out + 32'(INSTR_BYTES);
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = PC_out;
                        buf_load   = 1'b1;
                        state_d    = FC_VALID;
                    end
                end else if (redirect_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = word_align(redirect_pc);
                end
            end
            FC_VALID: begin
                if (redirect_valid) begin
                    PCWrite    = 1'b1;
                    PC_next    = word_align(redirect_pc);
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = FC_REQ;
                end else if (stall) begin
                    stall_hit = 1'b1;
                end else begin
                    if_valid_d = 1'b0;
                    state_d    = FC_REQ;
                end
            end
            default: state_d = FC_REQ;
        endcase

        if (rst) begin
            PCWrite  = 1'b0;
            PC_next  = PC_out;
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FC_REQ;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (buf_load)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_hit) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = buf_load ^ stall_hit;
`endif

endmodule
